// File: rtl/detector_paridade_pkg.sv
// Shared types for the framed serial parity checker.
// FSM state, parity mode and bit-counter sizing helper.
package detector_paridade_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    localparam int DEFAULT_DATA_BITS = 8;

    function automatic int bit_cnt_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

    localparam int DEFAULT_CNT_BITS = bit_cnt_width(DEFAULT_DATA_BITS);

endpackage

// File: rtl/contador_saturado.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module contador_saturado #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/detector_paridade_quadro.sv
// Framed serial parity checker: DATA_BITS data bits plus one parity bit
// per frame, runtime even/odd mode, saturating error count.
module detector_paridade_quadro
    import detector_paridade_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             sof,
    input  logic             odd_mode,
    input  logic             clr_count,
    output logic             out_bit,
    output logic             busy,
    output logic             frame_done,
    output logic             parity_err,
    output logic             frame_abort,
    output logic [CNT_W-1:0] err_count
);

    localparam int BW = bit_cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_CNT = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] FIRST_CNT = BW'(1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    par_mode_e       mode_q, mode_d;
    logic            out_bit_q, out_bit_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_abort_q, frame_abort_d;
    logic            err;
    logic            err_inc;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        mode_d        = mode_q;
        out_bit_d     = out_bit_q;
        frame_done_d  = 1'b0;
        parity_err_d  = parity_err_q;
        frame_abort_d = 1'b0;
        err           = 1'b0;
        err_inc       = 1'b0;

        if (in_valid) begin
            // sof always starts a fresh frame, abandoning any open one
            if (sof) begin
                mode_d        = par_mode_e'(odd_mode);
                out_bit_d     = in_bit;
                bit_cnt_d     = FIRST_CNT;
                state_d       = (DATA_BITS == 1) ? PARITY : DATA;
                frame_abort_d = (state_q != IDLE);
            end else begin
                unique case (state_q)
                    DATA: begin
                        out_bit_d = out_bit_q ^ in_bit;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_CNT) begin
                            state_d = PARITY;
                        end
                    end
                    PARITY: begin
                        err          = out_bit_q ^ in_bit ^ mode_q;
                        frame_done_d = 1'b1;
                        parity_err_d = err;
                        err_inc      = err;
                        state_d      = IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            mode_q        <= PAR_EVEN;
            out_bit_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            mode_q        <= mode_d;
            out_bit_q     <= out_bit_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    contador_saturado #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clr_count),
        .count (err_count)
    );

    assign out_bit     = out_bit_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign parity_err  = parity_err_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_detector_paridade_quadro.sv
// Scoreboard bench: randomized/directed frames against a frame-level
// parity model; two DUTs share stimulus (CNT_W=8 and CNT_W=2).
module tb_detector_paridade_quadro;

    localparam int DB = 8;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_bit, sof, odd_mode, clr_count;

    logic       ob8, busy8, done8, perr8, abort8;
    logic [7:0] cnt8;
    logic       ob2, busy2, done2, perr2, abort2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    detector_paridade_quadro #(.DATA_BITS(DB), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .sof(sof), .odd_mode(odd_mode), .clr_count(clr_count),
        .out_bit(ob8), .busy(busy8), .frame_done(done8),
        .parity_err(perr8), .frame_abort(abort8), .err_count(cnt8)
    );

    detector_paridade_quadro #(.DATA_BITS(DB), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .sof(sof), .odd_mode(odd_mode), .clr_count(clr_count),
        .out_bit(ob2), .busy(busy2), .frame_done(done2),
        .parity_err(perr2), .frame_abort(abort2), .err_count(cnt2)
    );

    typedef struct {
        bit busy;
        bit ob;
        bit done;
        bit perr;
        bit abort;
        int c8;
        int c2;
    } exp_t;

    exp_t q[$];

    // frame-level reference state
    bit m_in;
    int m_n;
    int m_ones;
    bit m_mode;
    bit m_perr;
    int m_c8;
    int m_c2;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic model_reset();
        m_in = 0; m_n = 0; m_ones = 0; m_mode = 0; m_perr = 0;
        m_c8 = 0; m_c2 = 0;
    endtask

    task automatic cycle(input logic v, input logic b, input logic s,
                         input logic odd, input logic clr);
        exp_t e;
        bit   err;
        @(negedge clk);
        in_valid = v; in_bit = b; sof = s; odd_mode = odd; clr_count = clr;
        e.done = 0;
        e.abort = 0;
        if (v) begin
            if (s) begin
                e.abort = m_in;
                m_in = 1; m_n = 1; m_ones = int'(b); m_mode = odd;
            end else if (m_in) begin
                if (m_n < DB) begin
                    m_n++;
                    m_ones += int'(b);
                end else begin
                    err = (((m_ones + int'(b)) % 2) != int'(m_mode));
                    e.done = 1;
                    m_perr = err;
                    m_in = 0;
                    if (err) begin
                        m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                        m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
                    end
                end
            end
        end
        if (clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end
        e.busy = m_in;
        e.ob = bit'(m_ones % 2);
        e.perr = m_perr;
        e.c8 = m_c8;
        e.c2 = m_c2;
        q.push_back(e);
    endtask

    task automatic idle(input int gap);
        repeat ($urandom_range(gap, 0)) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic frame(input logic [7:0] d, input int nb, input bit with_par,
                         input logic p, input logic odd, input int gap,
                         input logic clr_par);
        for (int i = 0; i < nb; i++) begin
            idle(gap);
            cycle(1'b1, d[i], i == 0, (i == 0) ? odd : 1'($urandom), 1'b0);
        end
        if (with_par) begin
            idle(gap);
            cycle(1'b1, p, 1'b0, 1'($urandom), clr_par);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy8, 0);
        chk({tag, "_outbit"}, ob8, 0);
        chk({tag, "_done"}, done8, 0);
        chk({tag, "_perr"}, perr8, 0);
        chk({tag, "_abort"}, abort8, 0);
        chk({tag, "_cnt8"}, cnt8, 0);
        chk({tag, "_cnt2"}, cnt2, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("busy", busy8, e.busy);
                chk("out_bit", ob8, e.ob);
                chk("frame_done", done8, e.done);
                chk("parity_err", perr8, e.perr);
                chk("frame_abort", abort8, e.abort);
                chk("err_count8", cnt8, e.c8);
                chk("err_count2", cnt2, e.c2);
                chk("frame_done2", done2, e.done);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] tc1;
        tc1 = 8'h4D;
        model_reset();
        reset = 1'b0;
        in_valid = 0; in_bit = 0; sof = 0; odd_mode = 0; clr_count = 0;
        #1;
        check_zero("por");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // stray bits in IDLE are dropped
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // even mode, good and bad parity
        frame(tc1, DB, 1, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        frame(tc1, DB, 1, 1'b1, 1'b0, 0, 1'b0);
        idle(2);
        frame(tc1, DB, 1, 1'b0, 1'b0, 0, 1'b0);

        // odd mode, odd_mode wiggles mid-frame
        frame(8'h01, DB, 1, 1'b0, 1'b1, 0, 1'b0);
        frame(8'h01, DB, 1, 1'b1, 1'b1, 0, 1'b0);

        // gaps between bits
        for (int k = 0; k < 4; k++) begin
            frame(tc1, DB, 1, 1'(k % 2), 1'b0, 3, 1'b0);
        end

        // aborts in DATA and PARITY states
        frame(8'hA5, 5, 0, 1'b0, 1'b0, 1, 1'b0);
        frame(8'h3C, DB, 1, 1'b0, 1'b1, 1, 1'b0);
        frame(8'hFF, DB, 0, 1'b0, 1'b0, 0, 1'b0);
        frame(8'h81, DB, 1, 1'b1, 1'b0, 0, 1'b0);

        // async reset mid-frame
        frame(8'h5A, 4, 0, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        frame(tc1, DB, 1, 1'b1, 1'b0, 0, 1'b0);
        frame(tc1, DB, 1, 1'b0, 1'b0, 0, 1'b0);

        // saturation: five errored back-to-back frames
        for (int k = 0; k < 5; k++) begin
            frame(8'h07, DB, 1, 1'b0, 1'b0, 0, 1'b0);
        end
        // clear coincident with an error completion
        frame(8'h07, DB, 1, 1'b0, 1'b0, 0, 1'b1);
        frame(8'h07, DB, 1, 1'b0, 1'b0, 0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            frame(8'($urandom), ($urandom_range(9, 0) == 0) ? int'($urandom_range(DB, 1)) : DB,
                  ($urandom_range(7, 0) != 0), 1'($urandom), 1'($urandom),
                  int'($urandom_range(2, 0)), ($urandom_range(9, 0) == 0));
            if ($urandom_range(5, 0) == 0) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/detector_paridade_quadro.md
Name: detector_paridade_quadro

Overview:
Framed serial parity checker, parametrised in word length and CNT_W, with runtime even/odd mode.
- Accepts a serial stream qualified by in_valid. Frames are delimited by sof.
- Each frame is DATA_BITS data bits followed by one parity bit.
- Flags a parity error per frame and keeps a saturating error count.
- Sits after a serial receiver / deserialiser front-end; feeds status/error logic.

Parameters:
DATA_BITS, 8, data bits per frame (>=1), parity bit excluded
CNT_W, 8, width of err_count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  in_bit/sof are valid this cycle; bits accepted only when 1
in_bit  in  1  serial data/parity bit
sof  in  1  start of frame; qualifies in_bit as first data bit (ignored when in_valid=0)
odd_mode  in  1  0 = even parity, 1 = odd parity; sampled only on accepted sof
clr_count  in  1  synchronous clear of err_count
out_bit  out  1  running XOR of data bits accepted in current frame
busy  out  1  1 while a frame is in progress (state != IDLE)
frame_done  out  1  one-cycle pulse, cycle after the parity bit is accepted
parity_err  out  1  result of the last completed frame; updated with frame_done, held otherwise
frame_abort  out  1  one-cycle pulse when an in-progress frame is restarted by sof
err_count  out  CNT_W  number of errored frames, saturating

Behaviour:
- Reset (reset=0, async): state=IDLE, bit counter=0, out_bit=0, busy=0, frame_done=0, parity_err=0, frame_abort=0, err_count=0. Takes effect immediately, including mid-frame; the partial frame is discarded.
- FSM states: IDLE, DATA, PARITY. All outputs are registered.
- Nothing advances in any state on a cycle with in_valid=0. This includes counters, out_bit and mode. Gaps of any length are legal.
- IDLE:
  - in_valid & sof: latch odd_mode into mode_q; out_bit<=in_bit; bit_cnt<=1.
  - Next state is DATA, or PARITY if DATA_BITS==1.
  - in_valid & !sof: ignored; the bit is dropped.
- DATA:
  - in_valid & !sof: out_bit<=out_bit^in_bit; bit_cnt++.
  - When the accepted bit is bit number DATA_BITS, go to PARITY.
- PARITY:
  - in_valid & !sof: err = out_bit ^ in_bit ^ mode_q.
  - Next cycle: frame_done=1, parity_err=err.
  - err_count increments if err=1, saturating at 2^CNT_W-1.
  - State returns to IDLE; out_bit holds its value until the next sof.
- sof with in_valid in DATA or PARITY:
  - Current frame is abandoned; frame_abort pulses next cycle.
  - No frame_done; parity_err and err_count are unchanged.
  - The bit is taken as data bit 1 of a new frame (mode re-latched, out_bit<=in_bit, bit_cnt<=1).
- Back-to-back frames: sof may arrive in the IDLE cycle coinciding with the frame_done pulse. There are no dead cycles between frames.
- clr_count: err_count<=0 next cycle. If it coincides with an error increment, the clear wins (result 0).
- bit_cnt width is $clog2(DATA_BITS+1). Bit order has no effect on the result.

Decomposition:
- Package detector_paridade_pkg holds:
  - state enum (IDLE, DATA, PARITY), 2-bit;
  - parity-mode enum (PAR_EVEN=0, PAR_ODD=1);
  - helper localparam for bit_cnt width.
- One natural sub-module: contador_saturado (params WIDTH; ports clk, reset, inc, clr, count; clear priority). Used for err_count.

Test Plan:
1. DATA_BITS=8, even. sof + data 1,0,1,1,0,0,1,0 (4 ones), parity 0 -> frame_done 1 cycle later, parity_err=0, err_count=0, out_bit=0.
2. Same frame with parity 1 -> parity_err=1, err_count=1. Then a good frame -> parity_err=0, err_count still 1.
3. Odd mode, data 0x01 (one 1), parity 0 -> parity_err=0. Repeat with parity 1 -> parity_err=1. Toggling odd_mode mid-frame has no effect.
4. Test-case 1 with in_valid low for 0-3 random cycles between bits -> identical results. frame_done only after the 9th accepted bit; busy=1 throughout.
5. sof after 5 data bits -> frame_abort pulse, no frame_done, err_count unchanged. The following 8 bits+parity complete the new frame correctly. reset=0 mid-frame -> all outputs 0 asynchronously, and the next sof frame is correct.
6. CNT_W=2: 5 errored frames -> err_count 1,2,3,3,3. clr_count in the same cycle as an error completion -> err_count=0. Back-to-back frames with sof during the frame_done cycle -> both frames checked.
